// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage_if
//  Description : Bundle of the fetch/hazard-side inputs and decode-side
//                outputs of the IF/ID pipeline register.
//                  instr_in   [15:0]  instruction from fetch
//                  pc2_in     [15:0]  PC+2 from fetch
//                  stall              hold the stage contents
//                  flush              squash the stage contents
//                  instr_out  [15:0]  instruction to decode
//                  pc2_out    [15:0]  PC+2 to decode
//                  valid_out          instr_out is a real fetched instruction
//                  halt_out           a HALT is held in the stage
//                  fetch_hold         tell fetch to hold the PC
//                  err                sticky stall-watchdog error
//                master : the environment (fetch, hazard unit, decode)
//                slave  : the pipeline register itself
//  Revision    : 1.0  initial release
// ============================================================================
interface if_id_stage_if;
  logic [15:0] instr_in;
  logic [15:0] pc2_in;
  logic        stall;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc2_out;
  logic        valid_out;
  logic        halt_out;
  logic        fetch_hold;
  logic        err;

  modport master (
    output instr_in, pc2_in, stall, flush,
    input  instr_out, pc2_out, valid_out, halt_out, fetch_hold, err
  );

  modport slave (
    input  instr_in, pc2_in, stall, flush,
    output instr_out, pc2_out, valid_out, halt_out, fetch_hold, err
  );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : IF/ID pipeline register. Captures instruction and PC+2 from
//                fetch, supports stall (hold) and flush (NOP bubble), freezes
//                the front end on HALT until flushed or reset, and runs a
//                stall watchdog with a sticky error flag.
//  Ports       : clk   clock, rising edge
//                rst   asynchronous active-high reset
//                bus   if_id_stage_if.slave (see interface for signal list)
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_stage #(
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  if_id_stage_if.slave       bus
);

  localparam logic [1:0] c_EMPTY  = 2'd0;
  localparam logic [1:0] c_FULL   = 2'd1;
  localparam logic [1:0] c_HALTED = 2'd2;

  localparam logic [7:0] c_LIMIT  = 8'(STALL_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q,   pc2_d;
  logic        valid_q, valid_d;
  logic        halt_q,  halt_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        err_q,   err_d;

  logic        w_is_halt;
  logic        w_stall_edge;

  assign w_is_halt    = (bus.instr_in[15:11] == HALT_OPCODE);
  assign w_stall_edge = bus.stall & ~bus.flush;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_EMPTY;
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    halt_d  = halt_q;

    if (bus.flush) begin
      // A HALT may be speculative, so flush also releases HALTED.
      // PC+2 is deliberately left as-is.
      state_d = c_EMPTY;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end else if (state_q == c_HALTED) begin
      // Frozen until flush or reset.
      state_d = c_HALTED;
    end else if (bus.stall) begin
      state_d = state_q;
    end else begin
      instr_d = bus.instr_in;
      pc2_d   = bus.pc2_in;
      valid_d = 1'b1;
      if (w_is_halt) begin
        state_d = c_HALTED;
        halt_d  = 1'b1;
      end else begin
        state_d = c_FULL;
        halt_d  = 1'b0;
      end
    end

    // Watchdog: counts consecutive stall edges (stall wins over HALTED here),
    // saturating so it can never wrap back below the limit.
    if (w_stall_edge) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
    end else begin
      cnt_d = 8'd0;
    end
    err_d = err_q | (w_stall_edge & (cnt_d == c_LIMIT));
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    bus.instr_out  = instr_q;
    bus.pc2_out    = pc2_q;
    bus.valid_out  = valid_q;
    bus.halt_out   = halt_q;
    bus.err        = err_q;
    bus.fetch_hold = (bus.stall | (state_q == c_HALTED)) & ~bus.flush;
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Directed self-checking bench for the IF/ID pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_stage;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  if_id_stage_if bus ();

  if_id_stage #(
    .NOP_INSTR   (16'h0800),
    .HALT_OPCODE (5'b00000),
    .STALL_LIMIT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if (bus.instr_out !== 16'h0800) begin n_err++; $display("FAIL rst_instr: got %h want 0800", bus.instr_out); end
    n_vec++; if (bus.pc2_out !== 16'h0000) begin n_err++; $display("FAIL rst_pc2: got %h want 0000", bus.pc2_out); end
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid_out); end
    n_vec++; if (bus.halt_out !== 1'b0) begin n_err++; $display("FAIL rst_halt: got %b want 0", bus.halt_out); end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.err); end
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL rst_fetch_hold: got %b want 0", bus.fetch_hold); end
    #10;
    rst = 1'b0;
  endtask

  task automatic test_load;
    bus.instr_in = 16'h4123; bus.pc2_in = 16'h0002; bus.stall = 1'b0; bus.flush = 1'b0;
    tick;
    n_vec++; if (bus.instr_out !== 16'h4123) begin n_err++; $display("FAIL load_instr: got %h want 4123", bus.instr_out); end
    n_vec++; if (bus.pc2_out !== 16'h0002) begin n_err++; $display("FAIL load_pc2: got %h want 0002", bus.pc2_out); end
    n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b want 1", bus.valid_out); end
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL load_fetch_hold: got %b want 0", bus.fetch_hold); end
  endtask

  task automatic test_stall;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instr_in = 16'h7000 + 16'(i);
      bus.pc2_in   = 16'h0100 + 16'(i);
      tick;
      n_vec++; if (bus.instr_out !== 16'h4123) begin n_err++; $display("FAIL stall_instr[%0d]: got %h want 4123", i, bus.instr_out); end
      n_vec++; if (bus.pc2_out !== 16'h0002) begin n_err++; $display("FAIL stall_pc2[%0d]: got %h want 0002", i, bus.pc2_out); end
      n_vec++; if (bus.fetch_hold !== 1'b1) begin n_err++; $display("FAIL stall_fetch_hold[%0d]: got %b want 1", i, bus.fetch_hold); end
    end
    // Release: overwrite of the FULL stage with a new instruction.
    bus.stall = 1'b0; bus.instr_in = 16'h4200; bus.pc2_in = 16'h0004;
    tick;
    n_vec++; if (bus.instr_out !== 16'h4200) begin n_err++; $display("FAIL release_instr: got %h want 4200", bus.instr_out); end
    n_vec++; if (bus.pc2_out !== 16'h0004) begin n_err++; $display("FAIL release_pc2: got %h want 0004", bus.pc2_out); end
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL release_fetch_hold: got %b want 0", bus.fetch_hold); end
  endtask

  task automatic test_halt;
    bus.instr_in = 16'h0000; bus.pc2_in = 16'h0006;
    tick;
    n_vec++; if (bus.halt_out !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %b want 1", bus.halt_out); end
    n_vec++; if (bus.fetch_hold !== 1'b1) begin n_err++; $display("FAIL halt_fetch_hold: got %b want 1", bus.fetch_hold); end
    n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL halt_valid: got %b want 1", bus.valid_out); end
    bus.instr_in = 16'h4555; bus.pc2_in = 16'h0008;
    tick;
    n_vec++; if (bus.instr_out !== 16'h0000) begin n_err++; $display("FAIL halt_frozen_instr: got %h want 0000", bus.instr_out); end
    n_vec++; if (bus.pc2_out !== 16'h0006) begin n_err++; $display("FAIL halt_frozen_pc2: got %h want 0006", bus.pc2_out); end
    bus.stall = 1'b1;
    tick;
    n_vec++; if (bus.halt_out !== 1'b1) begin n_err++; $display("FAIL halt_stall_flag: got %b want 1", bus.halt_out); end
    bus.stall = 1'b0;
    tick;
    n_vec++; if (bus.instr_out !== 16'h0000) begin n_err++; $display("FAIL halt_unstall_instr: got %h want 0000", bus.instr_out); end
    n_vec++; if (bus.fetch_hold !== 1'b1) begin n_err++; $display("FAIL halt_unstall_fetch_hold: got %b want 1", bus.fetch_hold); end
    bus.flush = 1'b1;
    #1;
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL halt_flush_fetch_hold: got %b want 0", bus.fetch_hold); end
    tick;
    bus.flush = 1'b0;
    #1;
    n_vec++; if (bus.instr_out !== 16'h0800) begin n_err++; $display("FAIL flush_instr: got %h want 0800", bus.instr_out); end
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.valid_out); end
    n_vec++; if (bus.halt_out !== 1'b0) begin n_err++; $display("FAIL flush_halt: got %b want 0", bus.halt_out); end
    n_vec++; if (bus.pc2_out !== 16'h0006) begin n_err++; $display("FAIL flush_pc2_hold: got %h want 0006", bus.pc2_out); end
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL flush_fetch_hold: got %b want 0", bus.fetch_hold); end
  endtask

  task automatic test_stall_empty;
    bus.stall = 1'b1; bus.instr_in = 16'h4999; bus.pc2_in = 16'h0010;
    tick;
    n_vec++; if (bus.instr_out !== 16'h0800) begin n_err++; $display("FAIL empty_stall_instr: got %h want 0800", bus.instr_out); end
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL empty_stall_valid: got %b want 0", bus.valid_out); end
    bus.stall = 1'b0;
    tick;
    n_vec++; if (bus.instr_out !== 16'h4999) begin n_err++; $display("FAIL empty_unstall_instr: got %h want 4999", bus.instr_out); end
  endtask

  task automatic test_stall_flush;
    bus.instr_in = 16'h4321; bus.pc2_in = 16'h0008;
    tick;
    bus.stall = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    bus.flush = 1'b1;
    #1;
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL sf_fetch_hold: got %b want 0", bus.fetch_hold); end
    tick;
    bus.flush = 1'b0;
    n_vec++; if (bus.instr_out !== 16'h0800) begin n_err++; $display("FAIL sf_instr: got %h want 0800", bus.instr_out); end
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL sf_valid: got %b want 0", bus.valid_out); end
    n_vec++; if (bus.pc2_out !== 16'h0008) begin n_err++; $display("FAIL sf_pc2: got %h want 0008", bus.pc2_out); end
    // 10 earlier stall edges plus 15 more would trip unless flush cleared the count.
    for (int i = 0; i < 15; i++) tick;
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL sf_counter_cleared: err got %b want 0", bus.err); end
    bus.stall = 1'b0;
    tick;
  endtask

  task automatic test_watchdog;
    bus.stall = 1'b1;
    for (int i = 0; i < 15; i++) tick;
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL wd_15_err: got %b want 0", bus.err); end
    bus.stall = 1'b0;
    tick;
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL wd_drop_err: got %b want 0", bus.err); end
    bus.stall = 1'b1;
    for (int i = 0; i < 15; i++) tick;
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL wd_pre_trip_err: got %b want 0", bus.err); end
    tick;
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL wd_trip_err: got %b want 1", bus.err); end
    bus.stall = 1'b0; bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    tick;
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL wd_sticky_err: got %b want 1", bus.err); end
  endtask

  task automatic test_async_reset;
    bus.instr_in = 16'h0000; bus.pc2_in = 16'h000A;
    tick;
    n_vec++; if (bus.halt_out !== 1'b1) begin n_err++; $display("FAIL ar_pre_halt: got %b want 1", bus.halt_out); end
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL ar_pre_err: got %b want 1", bus.err); end
    // Mid-cycle, well clear of the next rising edge.
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.instr_out !== 16'h0800) begin n_err++; $display("FAIL ar_instr: got %h want 0800", bus.instr_out); end
    n_vec++; if (bus.pc2_out !== 16'h0000) begin n_err++; $display("FAIL ar_pc2: got %h want 0000", bus.pc2_out); end
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", bus.valid_out); end
    n_vec++; if (bus.halt_out !== 1'b0) begin n_err++; $display("FAIL ar_halt: got %b want 0", bus.halt_out); end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL ar_err: got %b want 0", bus.err); end
    n_vec++; if (bus.fetch_hold !== 1'b0) begin n_err++; $display("FAIL ar_fetch_hold: got %b want 0", bus.fetch_hold); end
    #2;
    rst = 1'b0;
    bus.instr_in = 16'h4ABC; bus.pc2_in = 16'h000C;
    tick;
    n_vec++; if (bus.instr_out !== 16'h4ABC) begin n_err++; $display("FAIL ar_reload_instr: got %h want 4abc", bus.instr_out); end
    n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL ar_reload_valid: got %b want 1", bus.valid_out); end
    n_vec++; if (bus.halt_out !== 1'b0) begin n_err++; $display("FAIL ar_reload_halt: got %b want 0", bus.halt_out); end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.instr_in = 16'h0000;
    bus.pc2_in   = 16'h0000;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;

    test_reset;
    test_load;
    test_stall;
    test_halt;
    test_stall_empty;
    test_stall_flush;
    test_watchdog;
    test_async_reset;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Pipeline register between the fetch stage and the decode stage.
- Captures the fetched instruction and PC+2 each cycle.
- Supports stall (hold contents) and flush (insert a NOP bubble).
- Detects HALT and freezes the front end until it is flushed or reset.
- Runs a stall watchdog that raises a sticky error.

Parameters:
NOP_INSTR, 16'h0800, encoding injected on reset and flush (opcode 00001).
HALT_OPCODE, 5'b00000, value of instr[15:11] that marks HALT.
STALL_LIMIT, 16, consecutive stall cycles that trip the watchdog; legal range 1..255.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
instr_in  in  16  instruction from fetch.
pc2_in  in  16  PC+2 from fetch.
stall  in  1  hazard unit: hold the stage contents.
flush  in  1  branch/jump resolution: squash the stage contents.
instr_out  out  16  instruction to decode.
pc2_out  out  16  PC+2 to decode.
valid_out  out  1  instr_out is a real fetched instruction.
halt_out  out  1  a HALT is held in the stage.
fetch_hold  out  1  to fetch: hold the PC (do not advance).
err  out  1  sticky watchdog error.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Every register clears immediately on rst, independent of clk.
- Reset values:
  - instr_out = NOP_INSTR, pc2_out = 16'h0000.
  - valid_out = 0, halt_out = 0, err = 0.
  - State = EMPTY, stall counter = 0.
- States:
  - EMPTY: bubble held.
  - FULL: valid instruction held.
  - HALTED: HALT held.
- Per rising edge, evaluate in this priority order:
  1. flush=1:
     - instr_out <= NOP_INSTR, valid_out <= 0, halt_out <= 0.
     - pc2_out holds its current value.
     - Next state EMPTY from any state, HALTED included, because a HALT may be speculative.
     - Stall counter <= 0.
     - flush overrides a simultaneous stall.
  2. State HALTED: hold all outputs. Leave only via flush or rst.
  3. stall=1: hold instr_out, pc2_out, valid_out and state.
  4. Otherwise (load):
     - instr_out <= instr_in, pc2_out <= pc2_in, valid_out <= 1.
     - If instr_in[15:11] == HALT_OPCODE: next state HALTED, halt_out <= 1.
     - Else: next state FULL.
- fetch_hold is combinational: fetch_hold = (stall | state==HALTED) & ~flush.
- Latency: one cycle from instr_in to instr_out. No bypass path.
- Watchdog:
  - 8-bit counter.
  - Increments on each edge where stall=1 and flush=0; saturates at 255.
  - Clears to 0 on any edge where stall=0 or flush=1.
  - When the counter reaches STALL_LIMIT, err <= 1 on that edge.
  - err stays 1 until rst. A flush does not clear err.
- Boundary conditions:
  - stall during HALTED: no effect.
  - stall in EMPTY: the bubble is held.
  - Load in FULL with no stall: the new instruction overwrites the old one.
  - rst mid-stall or mid-halt: immediate return to the reset values above.
  - instr_in and pc2_in are don't-care while stall=1, flush=1 or state is HALTED.

Test Plan:
- Reset, then load instr_in=16'h4123, pc2_in=16'h0002 -> next edge: instr_out=16'h4123, pc2_out=16'h0002, valid_out=1, fetch_hold=0.
- FULL holding 16'h4123, stall=1 for 3 cycles while instr_in changes -> outputs unchanged and fetch_hold=1 throughout; release -> new instr loads next edge.
- Load instr_in=16'h0000 -> halt_out=1, fetch_hold=1. Later instr_in=16'h4555 -> instr_out stays 16'h0000. flush=1 -> instr_out=16'h0800, valid_out=0, halt_out=0, fetch_hold=0.
- stall=1 and flush=1 on the same edge -> NOP inserted, valid_out=0, stall counter 0, fetch_hold=0 during that cycle.
- stall held for 16 cycles (STALL_LIMIT=16) -> err=1 on the 16th edge. Stall held 15 cycles then dropped -> err stays 0. After trip, flush -> err remains 1.
- Assert rst asynchronously mid-cycle while HALTED with err=1 -> all outputs return to reset values immediately, before the next clk edge.
